// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the stall/flush pipeline.
//               Entry layout matches the processor's 16-bit data path and
//               3-bit register file address.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package pipe_pkg;

    localparam int c_DATA_W   = 16;
    localparam int REG_ADDR_W = 3;

    // One in-flight pipeline entry; packed so it flattens to {data, dst, wr}
    typedef struct packed {
        logic [c_DATA_W-1:0]   data;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wr;
    } entry_t;

    localparam int c_ENTRY_W = $bits(entry_t);

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Single elastic register slice: a valid bit plus a flattened
//               entry. Loads when enabled, flush kills the valid bit only.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int ENTRY_W = c_ENTRY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [ENTRY_W-1:0] i_entry,
    output logic               o_valid,
    output logic [ENTRY_W-1:0] o_entry
);

    logic               r_valid;
    logic [ENTRY_W-1:0] r_entry;

    // Flush only clears the valid bit; the payload may stay stale because
    // nothing downstream looks at it without a valid qualifier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_entry <= i_entry;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/stall_flush_pipe.sv
`default_nettype none
// ============================================================================
// Module      : stall_flush_pipe
// Description : DEPTH-stage elastic pipeline buffer with valid/ready
//               back-pressure, bubble collapsing, synchronous flush,
//               registered occupancy count and a youngest-first forwarding
//               lookup port. Stage 0 is youngest, stage DEPTH-1 drives out.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module stall_flush_pipe
    import pipe_pkg::*;
#(
    parameter  int WIDTH = c_DATA_W,
    parameter  int DEPTH = 3,
    parameter  int DST_W = REG_ADDR_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DST_W-1:0] in_dst,
    input  logic             in_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DST_W-1:0] out_dst,
    output logic             out_wr,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    input  logic [DST_W-1:0] q_addr,
    output logic             q_hit,
    output logic [WIDTH-1:0] q_data
);

    localparam int c_ENT_W = WIDTH + DST_W + 1;

    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_adv;
    logic [DEPTH-1:0]   w_srcValid;
    logic [DEPTH-1:0]   w_nextValid;
    logic [c_ENT_W-1:0] w_entry    [DEPTH];
    logic [c_ENT_W-1:0] w_srcEntry [DEPTH];
    logic [WIDTH-1:0]   w_data     [DEPTH];
    logic [DST_W-1:0]   w_dst      [DEPTH];
    logic [DEPTH-1:0]   w_wr;
    logic [CNT_W-1:0]   w_nextCount;
    logic [CNT_W-1:0]   r_count;
    logic               w_hit;
    logic [WIDTH-1:0]   w_qData;

    // Move enables ripple from the output back: a stage may load if it is
    // empty or its own occupant moves on this edge.
    always_comb begin
        logic a;
        a = ~w_valid[DEPTH-1] | out_ready;
        w_adv[DEPTH-1] = a;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            a = ~w_valid[i] | a;
            w_adv[i] = a;
        end
    end

    assign in_ready = w_adv[0] & ~flush & reset;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign w_srcValid[i] = in_valid;
                assign w_srcEntry[i] = {in_data, in_dst, in_wr};
            end else begin : g_body
                assign w_srcValid[i] = w_valid[i-1];
                assign w_srcEntry[i] = w_entry[i-1];
            end

            pipe_stage_reg #(
                .ENTRY_W (c_ENT_W)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_adv[i]),
                .i_flush (flush),
                .i_valid (w_srcValid[i]),
                .i_entry (w_srcEntry[i]),
                .o_valid (w_valid[i]),
                .o_entry (w_entry[i])
            );

            assign w_data[i] = w_entry[i][c_ENT_W-1 -: WIDTH];
            assign w_dst[i]  = w_entry[i][DST_W:1];
            assign w_wr[i]   = w_entry[i][0];
        end
    endgenerate

    // Next-state valid bits mirror what each stage will hold after the edge.
    always_comb begin
        w_nextValid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nextValid[i] = flush ? 1'b0 : (w_adv[i] ? w_srcValid[i] : w_valid[i]);
        end
    end

    // Population count of the next-state valid bits.
    always_comb begin
        w_nextCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nextCount = w_nextCount + CNT_W'(w_nextValid[i]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_nextCount;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        w_hit   = 1'b0;
        w_qData = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_valid[i] && w_wr[i] && (w_dst[i] == q_addr)) begin
                w_hit   = 1'b1;
                w_qData = w_data[i];
            end
        end
    end

    assign count     = r_count;
    assign q_hit     = w_hit;
    assign q_data    = w_qData;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign out_dst   = w_dst[DEPTH-1];
    assign out_wr    = w_wr[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_stall_flush_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_stall_flush_pipe
// Description : Self-checking bench for stall_flush_pipe. A position-based
//               model tracks each in-flight entry and where it sits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_flush_pipe;

    localparam int DEPTH = 3;
    localparam int WIDTH = 16;
    localparam int DST_W = 3;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [DST_W-1:0] in_dst;
    logic             in_wr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DST_W-1:0] out_dst;
    logic             out_wr;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic [DST_W-1:0] q_addr;
    logic             q_hit;
    logic [WIDTH-1:0] q_data;

    always #5 clk = ~clk;

    stall_flush_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DST_W (DST_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dst    (in_dst),
        .in_wr     (in_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dst   (out_dst),
        .out_wr    (out_wr),
        .flush     (flush),
        .count     (count),
        .q_addr    (q_addr),
        .q_hit     (q_hit),
        .q_data    (q_data)
    );

    // Model: entries ordered oldest first, each with its stage position.
    typedef struct {
        logic [WIDTH-1:0] data;
        logic [DST_W-1:0] dst;
        logic             wr;
        int               pos;
    } ment_t;

    ment_t mq[$];
    int    planPos[$];
    logic  planSlot0Free;
    int    checks = 0;
    int    errors = 0;

    // Where every entry ends up after the next edge (-1 = retired).
    // An entry advances one slot if that slot is free after older moves.
    function automatic void plan(input logic oready);
        int prevNew;
        int np;
        planPos.delete();
        prevNew = DEPTH;
        for (int k = 0; k < mq.size(); k++) begin
            if (k == 0 && mq[k].pos == DEPTH - 1 && oready) np = -1;
            else if (mq[k].pos < DEPTH - 1 && mq[k].pos + 1 < prevNew) np = mq[k].pos + 1;
            else np = mq[k].pos;
            planPos.push_back(np);
            if (np >= 0) prevNew = np;
        end
        planSlot0Free = (prevNew != 0);
    endfunction

    function automatic logic expReady();
        plan(out_ready);
        return reset && !flush && planSlot0Free;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        logic             expOV;
        logic             expHit;
        logic [WIDTH-1:0] expQ;
        chk("in_ready", 32'(in_ready), 32'(expReady()));
        expOV = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
        chk("out_valid", 32'(out_valid), 32'(expOV));
        chk("count", 32'(count), 32'(mq.size()));
        if (expOV) begin
            chk("out_data", 32'(out_data), 32'(mq[0].data));
            chk("out_dst", 32'(out_dst), 32'(mq[0].dst));
            chk("out_wr", 32'(out_wr), 32'(mq[0].wr));
        end
        expHit = 1'b0;
        expQ   = '0;
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (!expHit && mq[k].wr && mq[k].dst == q_addr) begin
                expHit = 1'b1;
                expQ   = mq[k].data;
            end
        end
        chk("q_hit", 32'(q_hit), 32'(expHit));
        chk("q_data", 32'(q_data), 32'(expQ));
    endtask

    // Apply inputs mid-cycle, then compare outputs against the model.
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [DST_W-1:0] ds,
                         input logic w, input logic ordy, input logic fl, input logic [DST_W-1:0] qa);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_dst    = ds;
        in_wr     = w;
        out_ready = ordy;
        flush     = fl;
        q_addr    = qa;
        #1;
        checkModel();
    endtask

    task automatic idle(input logic ordy, input logic [DST_W-1:0] qa);
        drive(1'b0, '0, '0, 1'b0, ordy, 1'b0, qa);
    endtask

    // Advance the model across the rising edge using the held inputs.
    task automatic tick();
        ment_t nq[$];
        ment_t e;
        logic  acc;
        @(posedge clk);
        acc = expReady() && in_valid;
        if (!reset || flush) begin
            mq.delete();
        end else begin
            plan(out_ready);
            for (int k = 0; k < mq.size(); k++) begin
                if (planPos[k] >= 0) begin
                    e     = mq[k];
                    e.pos = planPos[k];
                    nq.push_back(e);
                end
            end
            if (acc) begin
                e.data = in_data;
                e.dst  = in_dst;
                e.wr   = in_wr;
                e.pos  = 0;
                nq.push_back(e);
            end
            mq = nq;
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_dst = '0; in_wr = 1'b0;
        out_ready = 1'b0; flush = 1'b0; q_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_dst", 32'(out_dst), 32'd0);
        chk("rst_out_wr", 32'(out_wr), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_q_hit", 32'(q_hit), 32'd0);
        chk("rst_q_data", 32'(q_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Fill and drain
        drive(1'b1, 16'h1111, 3'd1, 1'b1, 1'b0, 1'b0, 3'd1); tick();
        drive(1'b1, 16'h2222, 3'd2, 1'b1, 1'b0, 1'b0, 3'd1); tick();
        drive(1'b1, 16'h3333, 3'd3, 1'b1, 1'b0, 1'b0, 3'd2); tick();
        idle(1'b0, 3'd0);
        chk("fd_count", 32'(count), 32'd3);
        chk("fd_in_ready", 32'(in_ready), 32'd0);
        chk("fd_out0", 32'(out_data), 32'h1111);
        tick();
        idle(1'b1, 3'd0); chk("fd_ret0", 32'(out_data), 32'h1111); tick();
        idle(1'b1, 3'd0); chk("fd_ret1", 32'(out_data), 32'h2222); tick();
        idle(1'b1, 3'd0); chk("fd_ret2", 32'(out_data), 32'h3333); tick();
        idle(1'b0, 3'd0); chk("fd_empty", 32'(count), 32'd0); tick();

        // Asynchronous reset mid-stream
        drive(1'b1, 16'h0A0A, 3'd4, 1'b1, 1'b0, 1'b0, 3'd4); tick();
        drive(1'b1, 16'h0B0B, 3'd4, 1'b1, 1'b0, 1'b0, 3'd4); tick();
        idle(1'b0, 3'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_q_hit", 32'(q_hit), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_rel_ready", 32'(in_ready), 32'd1);

        // Bubble collapse
        drive(1'b1, 16'hA001, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0); tick();
        idle(1'b0, 3'd0); tick();
        drive(1'b1, 16'hB002, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0); tick();
        idle(1'b0, 3'd0); tick();
        idle(1'b1, 3'd2);
        chk("bub_count", 32'(count), 32'd2);
        chk("bub_out", 32'(out_data), 32'hA001);
        chk("bub_q_hit", 32'(q_hit), 32'd1);
        chk("bub_q_data", 32'(q_data), 32'hB002);
        tick();
        idle(1'b1, 3'd0); chk("bub_next", 32'(out_data), 32'hB002); tick();
        idle(1'b0, 3'd0); chk("bub_empty", 32'(count), 32'd0); tick();

        // Full chain with simultaneous retire and accept
        drive(1'b1, 16'hC001, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0); tick();
        drive(1'b1, 16'hC002, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0); tick();
        drive(1'b1, 16'hC003, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0); tick();
        drive(1'b1, 16'h4444, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0);
        chk("fr_in_ready", 32'(in_ready), 32'd1);
        tick();
        idle(1'b0, 3'd0);
        chk("fr_count", 32'(count), 32'd3);
        chk("fr_out", 32'(out_data), 32'hC002);
        tick();

        // Flush with a pending input
        drive(1'b1, 16'h5555, 3'd6, 1'b1, 1'b0, 1'b1, 3'd6);
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        idle(1'b0, 3'd6);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_q_hit", 32'(q_hit), 32'd0);
        tick();

        // Forwarding priority
        drive(1'b1, 16'hAAAA, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5); tick();
        drive(1'b1, 16'hBBBB, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5); tick();
        idle(1'b0, 3'd5); tick();
        idle(1'b0, 3'd5);
        chk("fw_young_hit", 32'(q_hit), 32'd1);
        chk("fw_young_data", 32'(q_data), 32'hBBBB);
        tick();
        idle(1'b0, 3'd2);
        chk("fw_miss_hit", 32'(q_hit), 32'd0);
        chk("fw_miss_data", 32'(q_data), 32'd0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 3'd5); tick();
        drive(1'b1, 16'hAAAA, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5); tick();
        drive(1'b1, 16'hBBBB, 3'd5, 1'b0, 1'b0, 1'b0, 3'd5); tick();
        idle(1'b0, 3'd5); tick();
        idle(1'b0, 3'd5);
        chk("fw_old_hit", 32'(q_hit), 32'd1);
        chk("fw_old_data", 32'(q_data), 32'hAAAA);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 7), 16'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                  3'($urandom_range(0, 7)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stall_flush_pipe.md
Name: stall_flush_pipe

Overview:
- Parametrised successor of the fixed-width inter-stage pipeline buffer.
- Chain of DEPTH elastic register stages, each carrying a WIDTH-bit payload, a destination register address and a write-enable flag.
- Adds valid/ready back-pressure with bubble collapsing, a synchronous flush, an occupancy count and a forwarding lookup port.
- Sits between any two processor stages (e.g. execute→memory) and replaces the two-clock latch/buffer pairs with a single-clock stage.

Parameters:
- WIDTH, 16, payload bits per stage.
- DEPTH, 3, number of register stages (≥1). Stage 0 is youngest, stage DEPTH-1 is oldest and drives the output.
- DST_W, 3, destination register address width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- in_valid, input, 1, producer presents an entry.
- in_ready, output, 1, chain accepts an entry this cycle.
- in_data, input, WIDTH, payload.
- in_dst, input, DST_W, destination register address.
- in_wr, input, 1, entry writes a register.
- out_valid, output, 1, oldest stage holds a valid entry.
- out_ready, input, 1, consumer takes the entry.
- out_data, output, WIDTH, oldest payload.
- out_dst, output, DST_W, oldest destination address.
- out_wr, output, 1, oldest write-enable.
- flush, input, 1, kill all entries.
- count, output, CNT_W, number of valid stages.
- q_addr, input, DST_W, forwarding query address.
- q_hit, output, 1, a valid in-flight entry with wr=1 targets q_addr.
- q_data, output, WIDTH, payload of the youngest matching entry.

Behaviour:
- Reset (reset=0, async): all valid bits, data, dst and wr registers clear to 0. Consequently out_valid=0, out_data=0, out_dst=0, out_wr=0, count=0, q_hit=0, q_data=0. in_ready=0 while reset is asserted; after release, in_ready=1.
- Per-stage state: valid_q[i], data_q[i], dst_q[i], wr_q[i].
- Move enables, computed combinationally from oldest to youngest:
  - adv[DEPTH-1] = !valid_q[DEPTH-1] | out_ready
  - adv[i] = !valid_q[i] | adv[i+1]
  - in_ready = adv[0] & !flush
- Clock edge without flush:
  - Stage i loads stage i-1 when adv[i]; its valid becomes valid_q[i-1].
  - Stage 0 loads the inputs when adv[0]; its valid becomes in_valid.
  - Stages with adv=0 hold all fields.
  - Bubbles therefore collapse: an empty stage is filled even while the output is stalled.
- Latency: an entry into an empty chain reaches the output after DEPTH edges. Throughput is 1 entry/cycle when out_ready=1.
- Full: all DEPTH stages valid and out_ready=0 → in_ready=0 and everything holds.
- Simultaneous out_ready with a full chain: the output retires and a new input is accepted on the same edge (in_ready=1).
- flush=1:
  - All valid_q clear on the next edge; the input is not accepted.
  - out_valid is still driven from valid_q during the flush cycle, but the entry counts as killed: the consumer must qualify the handshake with !flush.
  - Payload registers may hold stale data.
- Flush during reset: reset dominates.
- count: registered population of valid stages, updated every edge from next-state valid bits; range 0..DEPTH, never wraps.
- Forwarding lookup (combinational):
  - Scan stages 0..DEPTH-1; the first i with valid_q[i] & wr_q[i] & dst_q[i]==q_addr wins (youngest priority).
  - q_hit=1, q_data=data_q[i]. With no match, q_hit=0 and q_data=0.
  - Invalid stages never match even when their stale dst equals q_addr.
- Data-width rules: fields are copied unchanged, with no arithmetic.

Decomposition:
- Shared package pipe_pkg holds:
  - a typedef for the stage entry struct {data, dst, wr}, parametrised via localparams matching the processor's 16-bit data and 3-bit register address;
  - the constant REG_ADDR_W=3.
- One natural sub-module, pipe_stage_reg: a single valid/ready register slice (valid, entry, load enable, flush). It is instantiated DEPTH times by a generate loop.
- Lookup priority and the count logic stay in the top.

Test Plan:
- Reset mid-stream: fill 2 entries, pull reset=0 asynchronously between edges → out_valid, count, q_hit become 0 immediately. After release, in_ready=1.
- Fill and drain, DEPTH=3: push 0x1111, 0x2222, 0x3333 with out_ready=0 → count=3, in_ready=0, out_data=0x1111. Raise out_ready → 0x1111, 0x2222, 0x3333 retire on consecutive edges, then count=0.
- Bubble collapse: push A, idle one cycle, push B with out_ready=0 → after 4 edges stages 1 and 2 hold B and A contiguously, count=2.
- Full with simultaneous retire: full chain, out_ready=1, in_valid=1 with 0x4444 → same edge retires the oldest and accepts 0x4444, count stays 3.
- Flush: chain holding 3 entries, flush=1 with in_valid=1 → in_ready=0, next cycle count=0 and out_valid=0. The input entry is not present later.
- Forwarding priority: stages hold {dst=5, wr=1, 0xAAAA} (oldest) and {dst=5, wr=1, 0xBBBB} (youngest), q_addr=5 → q_hit=1, q_data=0xBBBB. Same setup with the youngest entry wr=0 → q_data=0xAAAA. q_addr=2 → q_hit=0, q_data=0.
